// File: rtl/instruction_sequencer.sv
// instruction_sequencer: fetch/decode/execute sequencer forwarding core words and running local control ops.
// Define SEQ_HALT_ON_ILLEGAL_EN to stop in HALT on opcode E/F instead of treating it as a NOP.
module instruction_sequencer #(
  parameter int WIDTH = 16,
  parameter int ROM_AW = 16,
  parameter logic [WIDTH-1:0] RESET_IP = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              run,
  output logic              rom_req,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic              rom_ack,
  input  logic [15:0]       rom_data,
  output logic [14:0]       instr_out,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [WIDTH-1:0]  mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic              mem_ack,
  input  logic [WIDTH-1:0]  mem_rdata,
  input  logic              reg_wr_en,
  input  logic [2:0]        reg_wr_sel,
  input  logic [WIDTH-1:0]  reg_wr_data,
  output logic [3:0]        flags_out,
  output logic [2:0]        state_out,
  output logic              illegal
);
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, FWD, MEM, HALT} state_t;
  state_t state, state_n, nx;
  logic [WIDTH-1:0] regs [8];
  logic [WIDTH-1:0] a, b, res, cv, ipn;
  logic [WIDTH:0] sum;
  logic [15:0] ir, ct;
  logic [3:0] flags, op, cond, fn;
  logic [2:0] ra, rb, cs;
  logic [ROM_AW-1:0] fa;
  logic disc, take, ex, ov, cw, done, hip, hlt, bad, fu;
  assign op = ir[14:11];
  assign cond = ir[10:7];
  assign ra = ir[6:4];
  assign rb = ir[3:1];
  assign a = regs[ra];
  assign b = regs[rb];
  // condition table indexed by cond; flags are {Z,O,S,C}
  assign ct = {!flags[0] | flags[3], flags[0] & !flags[3], !flags[2], flags[2], 1'b0, 1'b1,
               !flags[1], flags[1], !flags[0], flags[0], flags[3] | (flags[1] != flags[2]),
               flags[1] == flags[2], flags[1] != flags[2], !flags[3] & (flags[1] == flags[2]),
               !flags[3], flags[3]};
  assign take = ct[cond];
  assign bad = state == EXEC && !ir[0] && op >= 4'hE;
`ifdef SEQ_HALT_ON_ILLEGAL_EN
  assign hlt = bad;
`else
  assign hlt = 1'b0;
`endif
  assign ex = state == EXEC && !ir[0] && take;
  assign hip = reg_wr_en && reg_wr_sel == 3'd7;
  assign cw = (ex && op >= 4'd2 && op <= 4'd13) || (state == MEM && mem_ack && !mem_we);
  assign cs = (state == EXEC && op == 4'hD) ? 3'd7 : ra;
  assign cv = state == MEM ? mem_rdata : res;
  assign done = (state == EXEC && !ir[0] && !(ex && op <= 4'd1) && !hlt) ||
                (state == FWD && instr_ready) || (state == MEM && mem_ack);
  // host write beats a core write, which beats the implicit ip increment
  assign ipn = hip ? reg_wr_data : (cw && cs == 3'd7) ? cv : done ? regs[7] + WIDTH'(1) : regs[7];
  assign fu = ex && op >= 4'd3 && op <= 4'd11;
  assign res = sum[WIDTH-1:0];
  assign fn = {res == '0, ov, res[WIDTH-1], sum[WIDTH]};
  assign nx = run ? FETCH : IDLE;
  assign rom_req = state == FETCH;
  assign rom_addr = fa;
  assign instr_out = ir[15:1];
  assign instr_valid = state == FWD;
  assign mem_req = state == MEM;
  assign flags_out = flags;
  assign state_out = state;
  always_comb begin
    sum = '0;
    ov = 1'b0;
    case (op)
      4'h2: sum = {1'b0, b};
      4'h3, 4'h4: begin
        sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, op == 4'h4 && flags[0]};
        ov = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'h5, 4'h6: begin
        sum = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, op == 4'h6 && flags[0]};
        ov = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'h7: sum = {1'b0, a & b};
      4'h8: sum = {1'b0, a | b};
      4'h9: sum = {1'b0, a ^ b};
      4'hA: sum = {a, 1'b0};
      4'hB: sum = {a[0], 1'b0, a[WIDTH-1:1]};
      4'hC: sum = {1'b0, {(WIDTH-4){1'b0}}, flags};
      4'hD: sum = {1'b0, a};
      default: sum = '0;
    endcase
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = nx;
      FETCH: state_n = rom_ack ? ((disc || hip) ? nx : EXEC) : FETCH;
      EXEC:  state_n = ir[0] ? FWD : (take && op <= 4'd1) ? MEM : hlt ? HALT : nx;
      FWD:   state_n = instr_ready ? nx : FWD;
      MEM:   state_n = mem_ack ? nx : MEM;
      HALT:  state_n = hip ? IDLE : HALT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      for (int i = 0; i < 7; i++) regs[i] <= '0;
      regs[7] <= RESET_IP;
      flags <= '0;
      ir <= '0;
      disc <= 1'b0;
      fa <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_we <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state <= state_n;
      for (int i = 0; i < 7; i++)
        regs[i] <= (reg_wr_en && reg_wr_sel == 3'(i)) ? reg_wr_data : (cw && cs == 3'(i)) ? cv : regs[i];
      regs[7] <= ipn;
      if (fu) flags <= fn;
      if (state == FETCH && rom_ack) ir <= rom_data;
      // an ip rewrite mid-fetch lets the old request finish, then refetches from the new ip
      disc <= state == FETCH && !rom_ack && (disc || hip);
      if (state_n == FETCH && (state != FETCH || rom_ack)) fa <= ipn[ROM_AW-1:0];
      if (ex && op <= 4'd1) begin
        mem_addr <= b;
        mem_wdata <= a;
        mem_we <= op[0];
      end
      illegal <= illegal | bad;
    end
  end
endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: vector table of ALU ops plus hand sequences; ROM/RAM/core responders check against queues.
module tb_instruction_sequencer;
  logic clock = 0, reset_n = 0, run = 0;
  logic rom_req, rom_ack = 0;
  logic [15:0] rom_addr, rom_data = 0;
  logic [14:0] instr_out;
  logic instr_valid, instr_ready = 0;
  logic mem_req, mem_we, mem_ack = 0;
  logic [15:0] mem_addr, mem_wdata, mem_rdata = 0;
  logic reg_wr_en = 0;
  logic [2:0] reg_wr_sel = 0;
  logic [15:0] reg_wr_data = 0;
  logic [3:0] flags_out;
  logic [2:0] state_out;
  logic illegal;

  int n_cmp = 0, n_bad = 0;
  int rom_lat = 0, mem_lat = 0, fwd_lat = 0, last_hold = 0;
  int rom_cnt = 0, mem_cnt = 0, hold = 0;
  logic [15:0] rom [256];
  logic [15:0] ram_rdata = 0, mem_a0 = 0;
  logic [15:0] exp_fetch[$];
  logic [15:0] exp_load[$];
  logic [31:0] exp_store[$];
  logic [14:0] exp_fwd[$];
  localparam logic [15:0] NOP = 16'h1580;

  typedef struct {
    logic [3:0] op;
    logic cin;
    logic [15:0] a, b, r;
    logic [3:0] f;
  } vec_t;
  vec_t vt[16];

  instruction_sequencer dut (
    .clock(clock), .reset_n(reset_n), .run(run),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data),
    .instr_out(instr_out), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .reg_wr_en(reg_wr_en), .reg_wr_sel(reg_wr_sel), .reg_wr_data(reg_wr_data),
    .flags_out(flags_out), .state_out(state_out), .illegal(illegal)
  );

  initial forever #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [3:0] cond,
                                      input logic [2:0] ra, input logic [2:0] rb);
    return {1'b0, op, cond, ra, rb, 1'b0};
  endfunction

  task automatic clr_rom();
    for (int i = 0; i < 256; i++) rom[i] = NOP;
  endtask

  task automatic hw(input logic [2:0] sel, input logic [15:0] data);
    @(negedge clock);
    reg_wr_en = 1;
    reg_wr_sel = sel;
    reg_wr_data = data;
    @(negedge clock);
    reg_wr_en = 0;
  endtask

  // runs until the fetch of stop is seen, optionally injecting one host write on the first cycle in state hst
  task automatic run_prog(input logic [15:0] stop, input logic [2:0] hst, input logic [2:0] hsel,
                          input logic [15:0] hdat);
    bit hit = 0;
    bit armed = (hst != 3'd7);
    @(negedge clock);
    run = 1;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clock);
      reg_wr_en = 0;
      if (armed && state_out == hst) begin
        reg_wr_en = 1;
        reg_wr_sel = hsel;
        reg_wr_data = hdat;
        armed = 0;
      end
      if (rom_req && rom_addr == stop) hit = 1;
    end
    run = 0;
    chk("stop_reached", 32'(hit), 32'd1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      reg_wr_en = 0;
      if (state_out == 3'd0) break;
    end
    chk("back_to_idle", 32'(state_out), 32'd0);
  endtask

  initial forever begin
    @(negedge clock);
    if (rom_req) begin
      if (rom_cnt < rom_lat) begin
        rom_ack = 0;
        rom_cnt++;
      end else begin
        rom_ack = 1;
        rom_data = rom[rom_addr[7:0]];
        rom_cnt = 0;
        if (exp_fetch.size() > 0) chk("fetch_addr", 32'(rom_addr), 32'(exp_fetch.pop_front()));
      end
    end else begin
      rom_ack = 0;
      rom_cnt = 0;
    end
  end

  initial forever begin
    @(negedge clock);
    if (mem_req) begin
      if (mem_cnt == 0) mem_a0 = mem_addr;
      else chk("mem_addr_stable", 32'(mem_addr), 32'(mem_a0));
      if (mem_cnt < mem_lat) begin
        mem_ack = 0;
        mem_cnt++;
      end else begin
        mem_ack = 1;
        mem_rdata = ram_rdata;
        mem_cnt = 0;
        if (mem_we) begin
          if (exp_store.size() > 0) chk("store", {mem_addr, mem_wdata}, exp_store.pop_front());
          else begin
            n_cmp++;
            n_bad++;
            $display("FAIL store_unexpected: got %h expected none", {mem_addr, mem_wdata});
          end
        end else if (exp_load.size() > 0) chk("load_addr", 32'(mem_addr), 32'(exp_load.pop_front()));
      end
    end else begin
      mem_ack = 0;
      mem_cnt = 0;
    end
  end

  initial forever begin
    @(negedge clock);
    if (instr_valid) begin
      if (exp_fwd.size() > 0) chk("fwd_word", 32'(instr_out), 32'(exp_fwd[0]));
      else begin
        n_cmp++;
        n_bad++;
        $display("FAIL fwd_unexpected: got %h expected none", instr_out);
      end
      hold++;
      if (hold > fwd_lat) begin
        instr_ready = 1;
        if (exp_fwd.size() > 0) void'(exp_fwd.pop_front());
        last_hold = hold;
        hold = 0;
      end else instr_ready = 0;
    end else begin
      instr_ready = 0;
      hold = 0;
    end
  end

  initial begin
    vt[0]  = '{4'h3, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 4'h6};
    vt[1]  = '{4'h3, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 4'h9};
    vt[2]  = '{4'h4, 1'b1, 16'h0001, 16'h0001, 16'h0003, 4'h0};
    vt[3]  = '{4'h5, 1'b0, 16'h0005, 16'h0005, 16'h0000, 4'h8};
    vt[4]  = '{4'h5, 1'b0, 16'h0003, 16'h0005, 16'hFFFE, 4'h3};
    vt[5]  = '{4'h5, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 4'h4};
    vt[6]  = '{4'h6, 1'b1, 16'h0005, 16'h0002, 16'h0002, 4'h0};
    vt[7]  = '{4'h7, 1'b0, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'h0};
    vt[8]  = '{4'h8, 1'b0, 16'h0000, 16'h0000, 16'h0000, 4'h8};
    vt[9]  = '{4'h9, 1'b0, 16'hFFFF, 16'h8000, 16'h7FFF, 4'h0};
    vt[10] = '{4'hA, 1'b0, 16'h8001, 16'h0000, 16'h0002, 4'h1};
    vt[11] = '{4'hB, 1'b0, 16'h0003, 16'h0000, 16'h0001, 4'h1};
    vt[12] = '{4'h2, 1'b0, 16'h1111, 16'hABCD, 16'hABCD, 4'h8};
    vt[13] = '{4'hC, 1'b1, 16'h1111, 16'h0000, 16'h0009, 4'h9};
    vt[14] = '{4'h6, 1'b1, 16'h0000, 16'h0000, 16'hFFFF, 4'h3};
    vt[15] = '{4'h4, 1'b1, 16'h7FFF, 16'h0000, 16'h8000, 4'h6};
    clr_rom();
    repeat (3) @(negedge clock);
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_flags", 32'(flags_out), 32'd0);
    chk("rst_reqs", {29'd0, rom_req, mem_req, instr_valid}, 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    @(negedge clock);
    reset_n = 1;

    // SHR r6 seeds C from cin, then op r1,r2, then STORE r1 to 0x0100
    for (int k = 0; k < 16; k++) begin
      clr_rom();
      rom[0] = enc(4'hB, 4'hA, 3'd6, 3'd0);
      rom[1] = enc(vt[k].op, 4'hA, 3'd1, 3'd2);
      rom[2] = enc(4'h1, 4'hA, 3'd1, 3'd3);
      hw(3'd6, {15'd0, vt[k].cin});
      hw(3'd1, vt[k].a);
      hw(3'd2, vt[k].b);
      hw(3'd3, 16'h0100);
      hw(3'd7, 16'h0000);
      for (int j = 0; j < 4; j++) exp_fetch.push_back(16'(j));
      exp_store.push_back({16'h0100, vt[k].r});
      run_prog(16'd3, 3'd7, 3'd0, 16'd0);
      chk($sformatf("vec%0d_flags", k), 32'(flags_out), 32'(vt[k].f));
    end

    clr_rom();
    rom[0] = enc(4'h5, 4'hA, 3'd3, 3'd4);
    rom[1] = enc(4'hD, 4'h0, 3'd5, 3'd0);
    hw(3'd3, 16'd5);
    hw(3'd4, 16'd5);
    hw(3'd5, 16'h0040);
    hw(3'd7, 16'h0000);
    exp_fetch.push_back(16'h0000);
    exp_fetch.push_back(16'h0001);
    exp_fetch.push_back(16'h0040);
    exp_fetch.push_back(16'h0041);
    run_prog(16'h0041, 3'd7, 3'd0, 16'd0);
    chk("sub_eq_flags", 32'(flags_out), 32'h8);

    rom[1] = enc(4'hD, 4'h1, 3'd5, 3'd0);
    hw(3'd3, 16'd5);
    hw(3'd7, 16'h0000);
    exp_fetch.push_back(16'h0000);
    exp_fetch.push_back(16'h0001);
    exp_fetch.push_back(16'h0002);
    run_prog(16'h0002, 3'd7, 3'd0, 16'd0);

    clr_rom();
    rom[0] = enc(4'h0, 4'hA, 3'd1, 3'd0);
    rom[1] = enc(4'h1, 4'hA, 3'd1, 3'd0);
    ram_rdata = 16'hBEEF;
    mem_lat = 3;
    hw(3'd0, 16'h0010);
    hw(3'd7, 16'h0000);
    exp_load.push_back(16'h0010);
    exp_store.push_back({16'h0010, 16'hBEEF});
    for (int j = 0; j < 3; j++) exp_fetch.push_back(16'(j));
    run_prog(16'h0002, 3'd7, 3'd0, 16'd0);
    mem_lat = 0;

    clr_rom();
    rom[0] = 16'hA5A5;
    fwd_lat = 2;
    hw(3'd7, 16'h0000);
    exp_fwd.push_back(15'h52D2);
    exp_fetch.push_back(16'h0000);
    exp_fetch.push_back(16'h0001);
    run_prog(16'h0001, 3'd7, 3'd0, 16'd0);
    chk("fwd_hold_cycles", 32'(last_hold), 32'd3);
    fwd_lat = 0;

    // host write to r2 lands in the same cycle as the core ADD writing r2
    clr_rom();
    rom[0] = enc(4'h3, 4'hA, 3'd2, 3'd1);
    rom[1] = enc(4'h1, 4'hA, 3'd2, 3'd3);
    hw(3'd1, 16'h0001);
    hw(3'd2, 16'hFFFF);
    hw(3'd3, 16'h0200);
    hw(3'd7, 16'h0000);
    exp_store.push_back({16'h0200, 16'h1234});
    for (int j = 0; j < 3; j++) exp_fetch.push_back(16'(j));
    run_prog(16'h0002, 3'd2, 3'd2, 16'h1234);
    chk("collision_flags", 32'(flags_out), 32'h9);

    clr_rom();
    rom[0] = enc(4'hE, 4'hA, 3'd0, 3'd0);
    hw(3'd7, 16'h0000);
    exp_fetch.push_back(16'h0000);
    exp_fetch.push_back(16'h0001);
    run_prog(16'h0001, 3'd7, 3'd0, 16'd0);
    chk("illegal_set", 32'(illegal), 32'd1);

    // ip rewrite while the fetch of word 0 is outstanding: word 0 must be dropped
    clr_rom();
    rom[0] = enc(4'h1, 4'hA, 3'd1, 3'd1);
    rom_lat = 3;
    hw(3'd7, 16'h0000);
    exp_fetch.push_back(16'h0000);
    exp_fetch.push_back(16'h0020);
    exp_fetch.push_back(16'h0021);
    run_prog(16'h0021, 3'd1, 3'd7, 16'h0020);
    rom_lat = 0;

    clr_rom();
    rom[0] = enc(4'h0, 4'hA, 3'd1, 3'd0);
    mem_lat = 10;
    hw(3'd0, 16'h0010);
    hw(3'd7, 16'h0000);
    @(negedge clock);
    run = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (mem_req) break;
    end
    chk("mem_req_seen", 32'(mem_req), 32'd1);
    @(negedge clock);
    #2 reset_n = 0;
    #1;
    chk("async_mem_req_drop", 32'(mem_req), 32'd0);
    chk("async_state_idle", 32'(state_out), 32'd0);
    run = 0;
    @(negedge clock);
    reset_n = 1;
    mem_lat = 0;
    chk("post_rst_flags", 32'(flags_out), 32'd0);
    chk("post_rst_illegal", 32'(illegal), 32'd0);
    rom[0] = enc(4'h1, 4'hA, 3'd1, 3'd0);
    exp_store.push_back(32'h0000_0000);
    exp_fetch.push_back(16'h0000);
    exp_fetch.push_back(16'h0001);
    run_prog(16'h0001, 3'd7, 3'd0, 16'd0);

    repeat (3) @(negedge clock);
    chk("fetch_q_empty", 32'(exp_fetch.size()), 32'd0);
    chk("store_q_empty", 32'(exp_store.size()), 32'd0);
    chk("load_q_empty", 32'(exp_load.size()), 32'd0);
    chk("fwd_q_empty", 32'(exp_fwd.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
